// File: rtl/sequence_output_collector.sv
// Deserialises sorted serial frames into parallel words and buffers two frames behind valid/ready.
// Optional order checking is built when SEQ_COLLECT_ORDER_CHECK_EN is defined.
module sequence_output_collector #(
    parameter int DW      = 8,
    parameter int SEQ_LEN = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DW-1:0]         in_data,
    output logic [SEQ_LEN*DW-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_order_err,
    output logic                  overflow
);

    localparam int FW = SEQ_LEN * DW;
    localparam int IW = $clog2(SEQ_LEN);
    localparam logic [IW-1:0] LAST = IW'(SEQ_LEN - 1);

    logic [IW-1:0] idx_q;
    logic [FW-1:0] asm_q;
    logic [FW-1:0] frame_next;
    logic [FW-1:0] fifo_data [2];
    logic          rd_ptr;
    logic          wr_ptr;
    logic [1:0]    count;
    logic          push;
    logic          pop;
    logic          accept;

    assign push      = in_valid && (idx_q == LAST);
    assign pop       = out_valid && out_ready;
    // A full FIFO still accepts a frame when the head leaves on the same edge.
    assign accept    = push && ((count != 2'd2) || pop);
    assign out_valid = (count != 2'd0);
    assign out_data  = fifo_data[rd_ptr];

    always_comb begin
        frame_next = asm_q;
        for (int k = 0; k < SEQ_LEN; k++) begin
            if (idx_q == IW'(k)) begin
                frame_next[k*DW +: DW] = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            asm_q <= '0;
        end else if (in_valid) begin
            asm_q <= frame_next;
            if (idx_q == LAST) begin
                idx_q <= '0;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            count        <= 2'd0;
            overflow     <= 1'b0;
        end else begin
            if (accept) begin
                fifo_data[wr_ptr] <= frame_next;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (accept && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !accept) begin
                count <= count - 2'd1;
            end
            if (push && !accept) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef SEQ_COLLECT_ORDER_CHECK_EN
    logic [DW-1:0] prev_q;
    logic          err_q;
    logic          err_next;
    logic [1:0]    err_mem;

    // The final word's comparison is folded in before the error bit is stored.
    always_comb begin
        err_next = 1'b0;
        if (idx_q != '0) begin
            err_next = err_q | (in_data < prev_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= '0;
            err_q   <= 1'b0;
            err_mem <= 2'b00;
        end else begin
            if (in_valid) begin
                prev_q <= in_data;
                err_q  <= err_next;
            end
            if (accept) begin
                err_mem[wr_ptr] <= err_next;
            end
        end
    end

    assign out_order_err = out_valid & err_mem[rd_ptr];
`else
    assign out_order_err = 1'b0;
`endif

endmodule
